// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the 32-bit CPU datapath: sequences fetch/decode/execute/memory/writeback.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap undecoded opcodes in a TRAP state with illegal_op.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       ext_zero,
    output logic       halted,
    output logic       mem_err
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, ADDR,
        MEM_RD, WB_MEM, MEM_WR, BRANCH, JUMP, HALT, TRAP
    } state_t;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          mem_err_q;
    logic          mem_state, timeout_hit;

    // funct is decoded by the external ALU control when alu_op = 10
    logic unused_funct;
    assign unused_funct = ^funct;

    logic is_rtype, is_addi, is_andi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j;
    assign is_rtype = (opcode == 6'b000000);
    assign is_addi  = (opcode == 6'b001000);
    assign is_andi  = (opcode == 6'b001100);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_bne   = (opcode == 6'b000101);
    assign is_j     = (opcode == 6'b000010);

    assign mem_state   = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    assign timeout_hit = (MEM_TIMEOUT != 0) && mem_state && !mem_ready && (cnt == LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            cnt       <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state || !mem_state)
                cnt <= '0;
            else if (!mem_ready)
                cnt <= cnt + CW'(1);
            if (timeout_hit)
                mem_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        ext_zero   = 1'b0;
        halted     = 1'b0;
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)        state_next = DECODE;
                else if (timeout_hit) state_next = HALT;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                if (is_rtype)                          state_next = EXEC_R;
                else if (is_addi || is_andi || is_ori) state_next = EXEC_I;
                else if (is_lw || is_sw)               state_next = ADDR;
                else if (is_beq || is_bne)             state_next = BRANCH;
                else if (is_j)                         state_next = JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                else                                   state_next = TRAP;
`else
                else                                   state_next = FETCH;
`endif
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = WB_R;
            end
            WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = FETCH;
            end
            EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = is_addi ? 2'b00 : 2'b11;
                ext_zero   = is_andi || is_ori;
                state_next = WB_I;
            end
            WB_I: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = is_sw ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready)        state_next = WB_MEM;
                else if (timeout_hit) state_next = HALT;
            end
            WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_next = FETCH;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready)        state_next = FETCH;
                else if (timeout_hit) state_next = HALT;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                pc_write   = (is_beq && alu_zero) || (is_bne && !alu_zero);
                state_next = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                state_next = FETCH;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
        // Reset must silence the datapath immediately, not at the next edge
        if (rst) begin
            {pc_write, ir_write, mem_req, mem_we, iord, reg_write, reg_dst, mem_to_reg} = '0;
            {alu_src_a, alu_src_b, alu_op, pc_src, ext_zero, halted} = '0;
        end
    end

    assign mem_err = mem_err_q && !rst;

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_op = (state == TRAP) && !rst;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: expected output vectors are queued per cycle and compared at mid-cycle.
// Built with MC_ILLEGAL_TRAP_EN defined, the illegal-opcode scenario expects the TRAP behaviour.
module tb_mc_ctrl_fsm;

    localparam int TO = 4;
    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                           OP_ORI = 6'b001101, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                           OP_BAD = 6'b111111;

    typedef enum {T_FETCH, T_DECODE, T_EXEC_R, T_WB_R, T_EXEC_I, T_WB_I, T_ADDR,
                  T_MEM_RD, T_WB_MEM, T_MEM_WR, T_BRANCH, T_JUMP, T_HALT, T_TRAP} tst_t;

    typedef struct packed {
        logic       pc_write, ir_write, mem_req, mem_we, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       ext_zero, halted, mem_err;
    } outs_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [5:0] opcode = '0, funct = 6'h20;
    logic       alu_zero = 1'b0, mem_ready = 1'b0;
    logic       pc_write, ir_write, mem_req, mem_we, iord, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       ext_zero, halted, mem_err;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    outs_t obs, e;
    outs_t exp_q[$];
    int checks = 0, errors = 0;

    assign obs = {pc_write, ir_write, mem_req, mem_we, iord, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, alu_op, pc_src, ext_zero, halted, mem_err};

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .mem_req(mem_req),
        .mem_we(mem_we), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_src(pc_src), .ext_zero(ext_zero), .halted(halted), .mem_err(mem_err)
`ifdef MC_ILLEGAL_TRAP_EN
        , .illegal_op(illegal_op)
`endif
    );

    // Reference outputs for a state as described by the control table
    function automatic outs_t model(tst_t s, logic [5:0] op, logic z, logic rdy, logic err);
        outs_t o;
        o = '0;
        o.mem_err = err;
        case (s)
            T_FETCH:  begin o.mem_req = 1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
            T_DECODE: o.alu_src_b = 2'b11;
            T_EXEC_R: begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            T_WB_R:   begin o.reg_write = 1; o.reg_dst = 1; end
            T_EXEC_I: begin
                o.alu_src_a = 1; o.alu_src_b = 2'b10;
                o.alu_op    = (op == OP_ADDI) ? 2'b00 : 2'b11;
                o.ext_zero  = (op == OP_ANDI) || (op == OP_ORI);
            end
            T_WB_I:   o.reg_write = 1;
            T_ADDR:   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            T_MEM_RD: begin o.mem_req = 1; o.iord = 1; end
            T_WB_MEM: begin o.reg_write = 1; o.mem_to_reg = 1; end
            T_MEM_WR: begin o.mem_req = 1; o.mem_we = 1; o.iord = 1; end
            T_BRANCH: begin
                o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01;
                o.pc_write  = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z);
            end
            T_JUMP:   begin o.pc_src = 2'b10; o.pc_write = 1; end
            T_HALT:   o.halted = 1;
            default:  ;
        endcase
        return o;
    endfunction

    task automatic drive_cycle(input tst_t s, input logic rdy, input logic z, input logic err);
        mem_ready = rdy;
        alu_zero  = z;
        exp_q.push_back(model(s, opcode, z, rdy, err));
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2;
        exp_q.push_back('0);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("[TB] FAIL reset_hold got %h exp %h", obs, e); end
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(T_FETCH, 1'b0, 1'b0, 1'b0);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("[TB] FAIL reset_fetch got %h exp %h", obs, e); end
        @(negedge clk);
    endtask

    // Full instruction from FETCH with memory always ready, then one idle FETCH cycle
    task automatic test_instr(input string name, input logic [5:0] op, input logic z);
        tst_t seq[$];
        opcode = op;
        seq = {T_FETCH, T_DECODE};
        case (op)
            OP_R:                    begin seq.push_back(T_EXEC_R); seq.push_back(T_WB_R); end
            OP_ADDI, OP_ANDI, OP_ORI: begin seq.push_back(T_EXEC_I); seq.push_back(T_WB_I); end
            OP_LW: begin seq.push_back(T_ADDR); seq.push_back(T_MEM_RD); seq.push_back(T_WB_MEM); end
            OP_SW:                   begin seq.push_back(T_ADDR); seq.push_back(T_MEM_WR); end
            OP_BEQ, OP_BNE:          seq.push_back(T_BRANCH);
            OP_J:                    seq.push_back(T_JUMP);
            default:                 ;
        endcase
        seq.push_back(T_FETCH);
        foreach (seq[i]) begin
            drive_cycle(seq[i], (i == seq.size() - 1) ? 1'b0 : 1'b1, z, 1'b0);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("[TB] FAIL %s step%0d got %h exp %h", name, i, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_lw_stall();
        tst_t st[$] = {T_FETCH, T_DECODE, T_ADDR, T_MEM_RD, T_MEM_RD, T_MEM_RD, T_MEM_RD, T_WB_MEM, T_FETCH};
        logic rd[$] = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        opcode = OP_LW;
        foreach (st[i]) begin
            drive_cycle(st[i], rd[i], 1'b0, 1'b0);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("[TB] FAIL lw_stall step%0d got %h exp %h", i, obs, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_mem();
        tst_t st[$] = {T_FETCH, T_DECODE, T_ADDR, T_MEM_RD};
        logic rd[$] = {1'b1, 1'b1, 1'b1, 1'b0};
        opcode = OP_LW;
        foreach (st[i]) begin
            drive_cycle(st[i], rd[i], 1'b0, 1'b0);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("[TB] FAIL rst_mid_setup step%0d got %h exp %h", i, obs, e); end
            if (i < st.size() - 1) @(negedge clk);
        end
        rst = 1'b1;
        exp_q.push_back('0);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("[TB] FAIL rst_mid_async got %h exp %h", obs, e); end
        @(negedge clk);
        rst = 1'b0;
        drive_cycle(T_FETCH, 1'b0, 1'b0, 1'b0);
        #2;
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("[TB] FAIL rst_mid_release got %h exp %h", obs, e); end
        @(negedge clk);
    endtask

    task automatic test_illegal();
`ifdef MC_ILLEGAL_TRAP_EN
        tst_t st[$] = {T_FETCH, T_DECODE, T_TRAP, T_TRAP, T_TRAP};
`else
        tst_t st[$] = {T_FETCH, T_DECODE, T_FETCH};
`endif
        opcode = OP_BAD;
        foreach (st[i]) begin
            drive_cycle(st[i], (st[i] == T_FETCH && i > 0) ? 1'b0 : 1'b1, 1'b0, 1'b0);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("[TB] FAIL illegal step%0d got %h exp %h", i, obs, e); end
`ifdef MC_ILLEGAL_TRAP_EN
            checks++;
            if (illegal_op !== (st[i] == T_TRAP)) begin
                errors++;
                $display("[TB] FAIL illegal_op step%0d got %b exp %b", i, illegal_op, st[i] == T_TRAP);
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        tst_t st[$];
        logic rd[$];
        logic er[$];
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        opcode = OP_J;
        st = {T_FETCH, T_FETCH, T_FETCH, T_FETCH, T_HALT, T_HALT, T_HALT};
        rd = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        er = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        foreach (st[i]) begin
            drive_cycle(st[i], rd[i], 1'b0, er[i]);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("[TB] FAIL timeout_halt step%0d got %h exp %h", i, obs, e); end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        st = {T_FETCH, T_FETCH, T_FETCH, T_FETCH, T_DECODE, T_JUMP, T_FETCH};
        rd = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        foreach (st[i]) begin
            drive_cycle(st[i], rd[i], 1'b0, 1'b0);
            #2;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("[TB] FAIL timeout_edge step%0d got %h exp %h", i, obs, e); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_instr("ori", OP_ORI, 1'b0);
        test_instr("andi", OP_ANDI, 1'b0);
        test_instr("addi", OP_ADDI, 1'b0);
        test_instr("rtype", OP_R, 1'b0);
        test_instr("lw", OP_LW, 1'b0);
        test_instr("sw", OP_SW, 1'b0);
        test_instr("beq_taken", OP_BEQ, 1'b1);
        test_instr("beq_not", OP_BEQ, 1'b0);
        test_instr("bne_taken", OP_BNE, 1'b0);
        test_instr("bne_not", OP_BNE, 1'b1);
        test_instr("jump", OP_J, 1'b0);
        test_lw_stall();
        test_reset_mid_mem();
        test_illegal();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
